cpu_sequencer: RTL and testbench
================================

# cpu_sequencer

Multi-cycle instruction phase controller for the CPU core. It steps the datapath through fetch, decode, execute, memory-access and write-back, and stalls in memory-access until the memory/UART side acknowledges. It latches halt requests and keeps retired-instruction and stall-cycle counters for the bench. With no memory stalls, every instruction takes exactly 5 clocks; this is the cycle budget the testbench timing is built around.

## Interface
- `CNT_WIDTH`, default 32: width of the `retired` and `stall_cycles` counters.
- `clk`  in  1  system clock; everything is on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `run`  in  1  execution enable; sampled in IDLE and at the end of WB.
- `mem_need`  in  1  decoded instruction does a load, store or UART access; valid from DE onward.
- `mem_ack`  in  1  memory/UART transfer complete; only meaningful while `mem_req`=1.
- `halt_req`  in  1  decoded halt instruction; sampled only in EX.
- `rd_write`  in  1  decoded instruction writes rd; sampled in WB.
- `stage_oh`  out  5  one-hot current phase, bit0 IF … bit4 WB; all-zero in IDLE and HALT.
- `mem_req`  out  1  memory request; combinational from state.
- `pc_we`  out  1  PC update strobe, high for the single WB cycle.
- `regfile_we`  out  1  equals WB & `rd_write`.
- `halted`  out  1  high while in HALT.
- `retired`  out  CNT_WIDTH  count of completed instructions.
- `stall_cycles`  out  CNT_WIDTH  count of MA cycles with `mem_req`=1 and `mem_ack`=0.

## Operation
- States: IDLE, IF, DE, EX, MA, WB, HALT.
- Transitions:
  - IDLE→IF when `run`=1; otherwise stay in IDLE.
  - IF→DE→EX→MA unconditionally.
  - MA→WB when `mem_need`=0, or when `mem_need`=1 and `mem_ack`=1. Otherwise stay in MA.
  - WB→HALT when the halt latch is set.
  - WB→IF when `run`=1; WB→IDLE when `run`=0.
  - HALT is sticky; only `reset` leaves it.
- `mem_req` = (state==MA) & `mem_need`. The request holds until ack, and `mem_need` must stay stable while MA is held.
- Halt latch:
  - Set in EX when `halt_req`=1; cleared on entering IF.
  - The halting instruction still completes MA and WB and is counted in `retired`.
- Counters:
  - `retired` increments on each WB cycle.
  - `stall_cycles` increments on each stalled MA cycle.
  - Both wrap modulo 2^CNT_WIDTH and hold value in IDLE and HALT.
- Deasserting `run` mid-instruction has no effect until the WB decision; an instruction is never abandoned.
- `mem_ack` outside MA, or with `mem_need`=0, is ignored.

## Timing
- Reset values: state IDLE, `stage_oh`=0, `mem_req`=0, `pc_we`=0, `regfile_we`=0, `halted`=0, halt latch 0, `retired`=0, `stall_cycles`=0.
- Reset asserted mid-instruction forces IDLE immediately (asynchronously). It does not wait for a pending `mem_ack`.
- All outputs are decoded from registered state and counters; no input reaches an output combinationally, except `mem_need`→`mem_req` and `rd_write`→`regfile_we`.
- Latency:
  - `run` high in IDLE at edge N gives IF during cycle N+1 and WB during N+5.
  - `retired` shows the new value from N+6.
- Zero-stall throughput: one instruction per 5 cycles with `run` held high.
- With k stall cycles, an instruction takes 5+k cycles.
- `mem_ack` in the first MA cycle means zero stalls.

## Structure
- The shared `cpu_package` holds:
  - `typedef enum logic [2:0] seq_state_t` {IDLE, IF, DE, EX, MA, WB, HALT};
  - stage bit-index localparams `STG_IF`..`STG_WB`;
  - `CLOCK_PER_INSTRUCT` = 5, so bench and RTL agree on the value.
- One sub-module, `wrap_counter` (parameter WIDTH; ports `clk`, `reset`, `inc`, `count`), instantiated twice.
- Remainder: one `always_ff` state register plus a combinational next-state and output decode.

## Test plan
- Reset, then idle with `run`=0 for 20 cycles → `stage_oh`=0, `retired`=0, no `pc_we`.
- `run`=1, `mem_need`=0, 3 instructions → `stage_oh` walks 1,2,4,8,16 per instruction, `pc_we` pulses every 5 cycles, and `retired`=3 after 15 cycles of sequencing, with `stall_cycles`=0.
- `mem_need`=1, `mem_ack` withheld 8 cycles (the UART WAIT) → `mem_req` high for 9 cycles, instruction takes 13 cycles, `stall_cycles`=8, `retired`=1.
- `halt_req`=1 in EX of the 2nd instruction, `run` held high → WB completes, `retired`=2, `halted`=1, `stage_oh`=0, and the state stays frozen for 10 further cycles.
- `run` dropped during DE → WB still occurs, then IDLE. Reasserting `run` gives IF on the next cycle, and `regfile_we`=`rd_write` only in WB.
- `reset` pulsed while stalled in MA → `mem_req` falls without waiting for a clock edge and the counters clear. After release with `run`=1, IF follows on the next edge.

Source files
------------

// File: rtl/cpu_package.sv
// rtl/cpu_package.sv - shared sequencer state type and phase constants
package cpu_package;

  typedef enum logic [2:0] {IDLE, IF, DE, EX, MA, WB, HALT} seq_state_t;

  localparam int STG_IF = 0;
  localparam int STG_DE = 1;
  localparam int STG_EX = 2;
  localparam int STG_MA = 3;
  localparam int STG_WB = 4;

  localparam int CLOCK_PER_INSTRUCT = 5;

endpackage

// File: rtl/wrap_counter.sv
// rtl/wrap_counter.sv - free-running event counter that wraps at 2^WIDTH
module wrap_counter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      count <= '0;
    else if (inc)
      count <= count + 1'b1;
  end

endmodule

// File: rtl/cpu_sequencer.sv
// rtl/cpu_sequencer.sv - multi-cycle IF/DE/EX/MA/WB phase controller with halt latch
module cpu_sequencer
  import cpu_package::*;
#(
  parameter int CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 run,
  input  logic                 mem_need,
  input  logic                 mem_ack,
  input  logic                 halt_req,
  input  logic                 rd_write,
  output logic [4:0]           stage_oh,
  output logic                 mem_req,
  output logic                 pc_we,
  output logic                 regfile_we,
  output logic                 halted,
  output logic [CNT_WIDTH-1:0] retired,
  output logic [CNT_WIDTH-1:0] stall_cycles
);

  seq_state_t state, state_next;
  logic       halt_latch, halt_next;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      halt_latch <= 1'b0;
    end else begin
      state      <= state_next;
      halt_latch <= halt_next;
    end
  end

  always_comb begin
    state_next = state;
    halt_next  = halt_latch;
    case (state)
      IDLE: if (run) state_next = IF;
      IF:   state_next = DE;
      DE:   state_next = EX;
      EX: begin
        state_next = MA;
        if (halt_req) halt_next = 1'b1;
      end
      MA:   if (!mem_need || mem_ack) state_next = WB;
      WB: begin
        if (halt_latch)
          state_next = HALT;
        else if (run)
          state_next = IF;
        else
          state_next = IDLE;
      end
      HALT: state_next = HALT;
      default: state_next = IDLE;
    endcase
    // A fresh instruction never inherits a stale halt from the previous one.
    if (state_next == IF) halt_next = 1'b0;
  end

  always_comb begin
    stage_oh = '0;
    case (state)
      IF: stage_oh[STG_IF] = 1'b1;
      DE: stage_oh[STG_DE] = 1'b1;
      EX: stage_oh[STG_EX] = 1'b1;
      MA: stage_oh[STG_MA] = 1'b1;
      WB: stage_oh[STG_WB] = 1'b1;
      default: stage_oh = '0;
    endcase
  end

  assign mem_req    = (state == MA) && mem_need;
  assign pc_we      = (state == WB);
  assign regfile_we = pc_we && rd_write;
  assign halted     = (state == HALT);

  wrap_counter #(.WIDTH(CNT_WIDTH)) u_retired (
    .clk   (clk),
    .reset (reset),
    .inc   (pc_we),
    .count (retired)
  );

  wrap_counter #(.WIDTH(CNT_WIDTH)) u_stalls (
    .clk   (clk),
    .reset (reset),
    .inc   (mem_req && !mem_ack),
    .count (stall_cycles)
  );

endmodule

// File: tb/tb_cpu_sequencer.sv
// tb/tb_cpu_sequencer.sv - directed self-checking bench for cpu_sequencer
module tb_cpu_sequencer;
  import cpu_package::*;

  logic        clk = 1'b0;
  logic        reset, run, mem_need, mem_ack, halt_req, rd_write;
  logic [4:0]  stage_oh;
  logic        mem_req, pc_we, regfile_we, halted;
  logic [31:0] retired, stall_cycles;

  int tests = 0;
  int failed = 0;

  cpu_sequencer #(.CNT_WIDTH(32)) dut (
    .clk          (clk),
    .reset        (reset),
    .run          (run),
    .mem_need     (mem_need),
    .mem_ack      (mem_ack),
    .halt_req     (halt_req),
    .rd_write     (rd_write),
    .stage_oh     (stage_oh),
    .mem_req      (mem_req),
    .pc_we        (pc_we),
    .regfile_we   (regfile_we),
    .halted       (halted),
    .retired      (retired),
    .stall_cycles (stall_cycles)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      failed++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    run = 1'b0; mem_need = 1'b0; mem_ack = 1'b0; halt_req = 1'b0; rd_write = 1'b0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  int mreq_cnt;

  initial begin
    do_reset();

    // reset state and idle hold
    check("rst_stage", {27'd0, stage_oh}, 32'd0);
    check("rst_memreq", {31'd0, mem_req}, 32'd0);
    check("rst_halted", {31'd0, halted}, 32'd0);
    check("rst_retired", retired, 32'd0);
    check("rst_stalls", stall_cycles, 32'd0);
    for (int i = 0; i < 20; i++) begin
      tick();
      check("idle_stage", {27'd0, stage_oh}, 32'd0);
      check("idle_pcwe", {31'd0, pc_we}, 32'd0);
    end
    check("idle_retired", retired, 32'd0);

    // three zero-stall instructions
    run = 1'b1;
    for (int i = 0; i < 3 * CLOCK_PER_INSTRUCT; i++) begin
      tick();
      check("walk_stage", {27'd0, stage_oh}, 32'd1 << (i % 5));
      check("walk_pcwe", {31'd0, pc_we}, (i % 5 == 4) ? 32'd1 : 32'd0);
      if (i == 14) run = 1'b0;
    end
    tick();
    check("walk_retired", retired, 32'd3);
    check("walk_stalls", stall_cycles, 32'd0);
    check("walk_idle", {27'd0, stage_oh}, 32'd0);

    // 8-cycle memory wait
    do_reset();
    run = 1'b1; mem_need = 1'b1;
    mreq_cnt = 0;
    for (int c = 1; c <= 13; c++) begin
      tick();
      if (mem_req) mreq_cnt++;
      if (c == 12) mem_ack = 1'b1;
      if (c == 13) begin
        check("wait_wb", {27'd0, stage_oh}, 32'd16);
        check("wait_pcwe", {31'd0, pc_we}, 32'd1);
        run = 1'b0; mem_ack = 1'b0;
      end
    end
    check("wait_memreq_cycles", mreq_cnt, 32'd9);
    tick();
    check("wait_stalls", stall_cycles, 32'd8);
    check("wait_retired", retired, 32'd1);
    check("wait_idle", {27'd0, stage_oh}, 32'd0);

    // halt in EX of the second instruction
    do_reset();
    run = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      tick();
      halt_req = (c == 8);
      if (c == 8) check("halt_in_ex", {27'd0, stage_oh}, 32'd4);
      if (c == 10) check("halt_wb_pcwe", {31'd0, pc_we}, 32'd1);
    end
    halt_req = 1'b0;
    tick();
    check("halt_halted", {31'd0, halted}, 32'd1);
    check("halt_retired", retired, 32'd2);
    check("halt_stage", {27'd0, stage_oh}, 32'd0);
    for (int i = 0; i < 10; i++) begin
      tick();
      check("halt_sticky", {31'd0, halted}, 32'd1);
      check("halt_frozen_stage", {27'd0, stage_oh}, 32'd0);
    end
    check("halt_frozen_retired", retired, 32'd2);

    // run dropped during DE, then restart; regfile_we only in WB
    do_reset();
    run = 1'b1; rd_write = 1'b1;
    for (int c = 1; c <= 5; c++) begin
      tick();
      if (c == 2) run = 1'b0;
      check("rd_regfile_we", {31'd0, regfile_we}, (c == 5) ? 32'd1 : 32'd0);
    end
    check("rd_wb_stage", {27'd0, stage_oh}, 32'd16);
    tick();
    check("rd_idle", {27'd0, stage_oh}, 32'd0);
    check("rd_retired", retired, 32'd1);
    run = 1'b1; rd_write = 1'b0;
    tick();
    check("rd_restart_if", {27'd0, stage_oh}, 32'd1);
    for (int c = 2; c <= 5; c++) tick();
    check("rd_wb2_stage", {27'd0, stage_oh}, 32'd16);
    check("rd_no_write", {31'd0, regfile_we}, 32'd0);
    run = 1'b0;
    tick();

    // asynchronous reset while stalled in MA
    do_reset();
    run = 1'b1; mem_need = 1'b1;
    for (int c = 1; c <= 5; c++) tick();
    check("ar_memreq", {31'd0, mem_req}, 32'd1);
    check("ar_stalls_pre", stall_cycles, 32'd1);
    #2 reset = 1'b1;
    #1;
    check("ar_memreq_fall", {31'd0, mem_req}, 32'd0);
    check("ar_stalls_clr", stall_cycles, 32'd0);
    check("ar_stage_clr", {27'd0, stage_oh}, 32'd0);
    tick();
    reset = 1'b0; mem_need = 1'b0;
    tick();
    check("ar_restart_if", {27'd0, stage_oh}, 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
